// File: rtl/button_debounce_pkg.sv
// Shared types and helpers for the button debouncer.
// Optional feature macro: BUTTON_DEBOUNCE_LONG_PRESS_EN (long-press strobe).
package button_debounce_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    ST_RELEASED      = 2'd0,
    ST_CHECK_PRESS   = 2'd1,
    ST_PRESSED       = 2'd2,
    ST_CHECK_RELEASE = 2'd3
  } deb_state_e;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One debounce channel: two-flop synchronizer, four-state debounce FSM,
// saturating stability counter and registered press/release strobes.
// With BUTTON_DEBOUNCE_LONG_PRESS_EN defined, a hold counter adds a single
// long-press strobe per press; otherwise long_o is tied low.
module button_debounce_chan
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  ,
  parameter int LONG_CYCLES     = 50000000
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic clean_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam logic PRESS_LVL = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic REL_LVL   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam int   CNT_W     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic             sync1_q, sync2_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             seen_press_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign seen_press_s = (sync2_q == PRESS_LVL);
  // Saturating increment: the counter never wraps even if the FSM lingers.
  assign cnt_inc_s    = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);

  // Two-flop synchronizer for the asynchronous pad input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM next-state; the transition into a stable state happens when
  // the count would reach DEBOUNCE_CYCLES, so the clean level moves on the
  // same edge as the strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (seen_press_s) begin
          state_d = ST_CHECK_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_CHECK_PRESS: begin
        if (!seen_press_s) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          clean_d = PRESS_LVL;
          press_d = 1'b1;
        end else begin
          cnt_d   = cnt_inc_s;
        end
      end
      ST_PRESSED: begin
        if (!seen_press_s) begin
          state_d = ST_CHECK_RELEASE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_CHECK_RELEASE: begin
        if (seen_press_s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
          clean_d = REL_LVL;
          rel_d   = 1'b1;
        end else begin
          cnt_d   = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
        clean_d = REL_LVL;
      end
    endcase
  end

  // FSM, counter and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      clean_q <= REL_LVL;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign clean_o   = clean_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int HOLD_W = cnt_width(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1'b1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  // Hold counter: cleared on entering PRESSED, counts while PRESSED and
  // saturates at LONG_CYCLES so only one long strobe fires per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if ((state_q == ST_PRESSED) && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_ONE;
      long_d = (hold_q == (HOLD_MAX - HOLD_ONE));
    end else begin
      hold_d = hold_q;
    end
  end

  // Hold counter and long-press strobe flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button debouncer feeding a PIO input port directly.
// Optional feature macro: BUTTON_DEBOUNCE_LONG_PRESS_EN (long-press strobes);
// when undefined the long_press port stays present and reads zero.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] buttons_raw,
  output logic [WIDTH-1:0] buttons_clean,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press
);

  // Reject configurations the counters cannot honour.
  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 16777215) ||
      (LONG_CYCLES <= DEBOUNCE_CYCLES)) begin : g_bad_params
    $error("button_debounce: illegal DEBOUNCE_CYCLES/LONG_CYCLES");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    button_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
      ,
      .LONG_CYCLES     (LONG_CYCLES)
`endif
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw_i     (buttons_raw[i]),
      .clean_o   (buttons_clean[i]),
      .press_o   (press_pulse[i]),
      .release_o (release_pulse[i]),
      .long_o    (long_press[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (WIDTH=4, DEBOUNCE_CYCLES=4,
// LONG_CYCLES=16, ACTIVE_LOW=1). The reference model judges acceptance by the
// run length of identical synchronized samples, independent of FSM encoding.
module tb_button_debounce;

  localparam int W = 4;
  localparam int D = 4;
  localparam int L = 16;
  localparam logic PR = 1'b0;
  localparam logic RL = 1'b1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] buttons_raw = 4'hF;
  logic [W-1:0] buttons_clean, press_pulse, release_pulse, long_press;

  int checks = 0;
  int failures = 0;

  // model state
  logic [W-1:0] p1_m, p2_m, prev_m, clean_m, run_lvl_m;
  int           run_len_m [W];
  int           hold_m [W];
  logic [W-1:0] exp_press, exp_rel, exp_long;

  button_debounce #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .LONG_CYCLES(L)
  ) dut (
    .clk(clk), .reset_n(reset_n), .buttons_raw(buttons_raw),
    .buttons_clean(buttons_clean), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p1_m = 4'hF; p2_m = 4'hF; prev_m = 4'hF;
    clean_m = 4'hF; run_lvl_m = 4'hF;
    exp_press = 4'h0; exp_rel = 4'h0; exp_long = 4'h0;
    for (int i = 0; i < W; i++) begin
      run_len_m[i] = 0;
      hold_m[i] = 0;
    end
  endtask

  // One clock edge of the reference: the FSM sees raw from two edges ago;
  // a level is accepted once D identical samples in a row differ from clean.
  task automatic model_edge();
    logic seen;
    for (int i = 0; i < W; i++) begin
      seen = p2_m[i];
      p2_m[i] = p1_m[i];
      p1_m[i] = buttons_raw[i];
      exp_press[i] = 1'b0;
      exp_rel[i] = 1'b0;
      exp_long[i] = 1'b0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
      if (clean_m[i] == PR && prev_m[i] == PR && hold_m[i] < L) begin
        hold_m[i]++;
        if (hold_m[i] == L) exp_long[i] = 1'b1;
      end
`endif
      if (seen == run_lvl_m[i]) run_len_m[i]++;
      else begin
        run_lvl_m[i] = seen;
        run_len_m[i] = 1;
      end
      if (run_len_m[i] == D && clean_m[i] != seen) begin
        clean_m[i] = seen;
        if (seen == PR) begin
          exp_press[i] = 1'b1;
          hold_m[i] = 0;
        end else begin
          exp_rel[i] = 1'b1;
        end
      end
      prev_m[i] = seen;
    end
  endtask

  task automatic check_outputs();
    chk("clean", 32'(buttons_clean), 32'(clean_m));
    chk("press", 32'(press_pulse), 32'(exp_press));
    chk("release", 32'(release_pulse), 32'(exp_rel));
    chk("long", 32'(long_press), 32'(exp_long));
  endtask

  task automatic step(input logic [W-1:0] r);
    buttons_raw = r;
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
  endtask

  initial begin
    int first;
    int nlong;
    logic [W-1:0] pat;
    logic [W-1:0] rr;
    int thr;

    // reset state
    #1 reset_n = 1'b0;
    #2;
    chk("rst_clean", 32'(buttons_clean), 32'h0000000F);
    chk("rst_press", 32'(press_pulse), 32'h00000000);
    chk("rst_release", 32'(release_pulse), 32'h00000000);
    chk("rst_long", 32'(long_press), 32'h00000000);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    repeat (6) step(4'hF);

    // clean press on channel 0: strobe exactly on edge D+1
    first = -1;
    for (int n = 0; n < 8; n++) begin
      step(4'b1110);
      if (press_pulse[0] && first < 0) first = n;
    end
    chk("press_latency", 32'(first), 32'd5);
    repeat (8) step(4'hF);

    // bounce on channel 1, then steady low
    step(4'b1101); step(4'b1111); step(4'b1101); step(4'b1111);
    first = -1;
    for (int n = 0; n < 8; n++) begin
      step(4'b1101);
      if (press_pulse[1] && first < 0) first = n;
    end
    chk("bounce_latency", 32'(first), 32'd5);
    repeat (8) step(4'hF);

    // simultaneous press and release
    pat = 4'h0;
    for (int n = 0; n < 8; n++) begin
      step(4'b0000);
      if (pat == 4'h0) pat = press_pulse;
    end
    chk("simul_press", 32'(pat), 32'h0000000F);
    pat = 4'h0;
    for (int n = 0; n < 8; n++) begin
      step(4'b1111);
      if (pat == 4'h0) pat = release_pulse;
    end
    chk("simul_release", 32'(pat), 32'h0000000F);

    // long press on channel 2
    nlong = 0;
    for (int n = 0; n < 40; n++) begin
      step(4'b1011);
      if (long_press[2]) nlong++;
    end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    chk("long_count", 32'(nlong), 32'd1);
`else
    chk("long_count", 32'(nlong), 32'd0);
`endif
    repeat (10) step(4'hF);

    // reset in the middle of a press check (cnt=3 after edge 4)
    for (int n = 0; n < 5; n++) step(4'b1110);
    reset_n = 1'b0;
    #1;
    chk("midrst_clean", 32'(buttons_clean), 32'h0000000F);
    chk("midrst_press", 32'(press_pulse), 32'h00000000);
    @(posedge clk);
    #1;
    chk("midrst_press_hold", 32'(press_pulse), 32'h00000000);
    reset_n = 1'b1;
    model_reset();
    first = -1;
    for (int n = 0; n < 8; n++) begin
      step(4'b1110);
      if (press_pulse[0] && first < 0) first = n;
    end
    chk("post_reset_press", 32'(first), 32'd5);
    repeat (8) step(4'hF);

    // randomized segments: bouncy and calm
    rr = 4'hF;
    for (int seg = 0; seg < 12; seg++) begin
      thr = (seg % 2 == 0) ? 5 : 1;
      for (int n = 0; n < 40; n++) begin
        for (int i = 0; i < W; i++)
          if ($urandom_range(0, 9) < thr) rr[i] = ~rr[i];
        step(rr);
      end
    end
    repeat (30) step(4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of button channels; its outputs drive the PIO input port directly.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable samples needed to accept a level; legal range 2..2^24-1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 means the pressed level is 0 and the released level is 1.
REQ-004 SHALL have parameter LONG_CYCLES, default 50000000: pressed-hold cycles before a long-press pulse; must exceed DEBOUNCE_CYCLES.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port buttons_raw, input, WIDTH bits: asynchronous, bouncing pad inputs.
REQ-008 SHALL have port buttons_clean, output, WIDTH bits: debounced levels, same polarity as buttons_raw.
REQ-009 SHALL have port press_pulse, output, WIDTH bits: one-cycle strobe per accepted press.
REQ-010 SHALL have port release_pulse, output, WIDTH bits: one-cycle strobe per accepted release.
REQ-011 SHALL have port long_press, output, WIDTH bits: one-cycle strobe when a press has been held LONG_CYCLES.

Function
REQ-012 SHALL pass each raw bit through a two-flop synchronizer; s[i] is the second flop.
REQ-013 SHALL run one independent FSM per channel with states RELEASED, CHECK_PRESS, PRESSED, CHECK_RELEASE.
REQ-014 SHALL, in RELEASED, go to CHECK_PRESS with cnt=1 when s[i]==pressed level.
REQ-015 SHALL, in CHECK_PRESS, increment cnt while s[i]==pressed level; at cnt==DEBOUNCE_CYCLES, enter PRESSED.
REQ-016 SHALL, in CHECK_PRESS, return to RELEASED with cnt=0 when s[i]==released level, emitting no pulse.
REQ-017 SHALL apply the symmetric rules for PRESSED -> CHECK_RELEASE -> RELEASED, and CHECK_RELEASE -> PRESSED on bounce.
REQ-018 SHALL update buttons_clean[i] and assert press_pulse[i] or release_pulse[i] on the same edge the FSM enters PRESSED or RELEASED.
REQ-019 SHALL hold each pulse high for exactly one cycle.
REQ-020 SHALL meet this latency: if raw is stable from just before edge 0, the clean level changes on edge DEBOUNCE_CYCLES+1.
REQ-021 SHALL saturate every counter, never wrap, and size it with clog2 of its maximum value plus 1.
REQ-022 SHALL keep channels independent; simultaneous events on several channels produce simultaneous pulses.
REQ-023 SHALL never assert press_pulse[i] and release_pulse[i] in the same cycle.
REQ-024 SHALL drive all outputs from registers, with no combinational path from buttons_raw.

Reset
REQ-025 SHALL, while reset_n=0, clear synchronizers to the released level, FSMs to RELEASED, all counters to 0, and all pulses to 0.
REQ-026 SHALL set buttons_clean to all-ones when ACTIVE_LOW=1 and to all-zeros otherwise.
REQ-027 SHALL treat a button held through reset release as a new press: full debounce, then press_pulse.
REQ-028 SHALL abort any in-progress check on reset mid-operation, emitting no pulse.

Configuration
REQ-029 SHALL gate long-press logic with macro BUTTON_DEBOUNCE_LONG_PRESS_EN.
REQ-030 SHALL, when the macro is defined, count a hold counter in PRESSED (reset on entering PRESSED), pulse long_press[i] once at count==LONG_CYCLES, then saturate: one pulse per press.
REQ-031 SHALL, when the macro is undefined, remove the hold counter and tie long_press to 0; the port remains present.

Structure
REQ-032 SHALL place the FSM state enum and counter-width helper function in package button_debounce_pkg.
REQ-033 SHALL implement one channel (synchronizer, FSM, counters, pulses) in sub-module button_debounce_chan, instantiated WIDTH times by generate.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW=1)
REQ-034 SHALL verify clean press: raw[0] 1->0 before edge 0, held -> buttons_clean[0]=0 and press_pulse[0]=1 on edge 5 only.
REQ-035 SHALL verify bounce: raw[1] toggles 0,1,0,1 every cycle, then stays 0 -> no pulse during bounce; press_pulse[1] on edge 5 after the last toggle.
REQ-036 SHALL verify simultaneous events: raw[3:0]=4'b0000 at once -> press_pulse=4'b1111 in one cycle; release all -> release_pulse=4'b1111 in one cycle.
REQ-037 SHALL verify long press with macro on: hold raw[2]=0 for 40 cycles -> exactly one long_press[2] pulse; with macro off, long_press stays 0.
REQ-038 SHALL verify reset mid-check: assert reset_n=0 at cnt=3 -> buttons_clean=4'hF and no pulse; still-held button pulses again after full debounce.
